// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI transaction sequencer and its helpers:
//   - register map of the downstream SPI master (2-bit address space)
//   - control/status bit positions
//   - default per-byte poll timeout
//   - sequencer FSM state encoding
//   - small helpers that build slave-select and control words
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_TX   = 2'd1;
  localparam logic [1:0] ADDR_RX   = 2'd2;
  localparam logic [1:0] ADDR_SS   = 2'd3;

  localparam int START_BIT = 0;
  localparam int DONE_BIT  = 3;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd4096;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SEL     = 4'd1,
    ST_WAIT_TX = 4'd2,
    ST_GO      = 4'd3,
    ST_POLL    = 4'd4,
    ST_READ    = 4'd5,
    ST_RX_HOLD = 4'd6,
    ST_DESEL   = 4'd7,
    ST_DONE    = 4'd8
  } xfer_state_e;

  // Slave selects are active low, one bit per slave.
  function automatic logic [7:0] ss_select_mask(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

  // Control word that kicks off one byte: {prescaler, 0, cpha, cpol, start}.
  // Bit 3 overlays the read-only DONE status bit, so it is written as 0.
  function automatic logic [7:0] ctrl_start_word(input logic [3:0] pre,
                                                 input logic       pha,
                                                 input logic       pol);
    logic [7:0] word;
    word            = {pre, 1'b0, pha, pol, 1'b0};
    word[START_BIT] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/spi_poll_timer.sv
// ---------------------------------------------------------------------------
// spi_poll_timer
// 16-bit poll counter with synchronous clear, count enable and a terminal
// count flag. Usable by any master that polls a status bit with a bound.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous reset, active low
//   load   - clear the counter to zero (has priority over en)
//   en     - advance the counter by one
//   tc     - high while the counter equals TERMINAL
// ---------------------------------------------------------------------------
module spi_poll_timer #(
  parameter logic [15:0] TERMINAL = 16'd4095
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [15:0] count_q;

  // Counter stops at the terminal value so tc stays asserted until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign tc = (count_q == TERMINAL);

endmodule

// File: rtl/spi_xfer_engine.sv
// ---------------------------------------------------------------------------
// spi_xfer_engine
// Multi-byte transaction sequencer in front of an SPI master's register port.
// One command (slave, byte count, mode) selects the slave, then for each byte
// pulls a TX byte, writes it, starts the transfer, polls DONE, reads the RX
// byte and hands it downstream; finally deselects and pulses Done.
// Ports:
//   Clk, Rst_n                 - clock, asynchronous active-low reset
//   Start, SlaveIdx, Len       - command strobe, slave index, byte count
//   CPol, CPha, CPre           - SPI mode/prescaler, latched at Start
//   TxValid, TxByte, TxReady   - TX byte stream (TxReady pulses on consume)
//   RxValid, RxByte, RxReady   - RX byte stream (valid/ready handshake)
//   Busy, Done, Error          - status; Error is sticky until next Start
//   Addr, Wr, DataWr, DataRd   - SPI master register port (DataRd is
//                                combinational on Addr)
// ---------------------------------------------------------------------------
module spi_xfer_engine
  import spi_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic [2:0] SlaveIdx,
  input  logic [7:0] Len,
  input  logic       CPol,
  input  logic       CPha,
  input  logic [3:0] CPre,
  input  logic       TxValid,
  input  logic [7:0] TxByte,
  output logic       TxReady,
  output logic       RxValid,
  output logic [7:0] RxByte,
  input  logic       RxReady,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [1:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWr,
  input  logic [7:0] DataRd
);

  xfer_state_e state_q, state_d;

  logic [2:0] slave_q;
  logic [7:0] remaining_q;
  logic       cpol_q;
  logic       cpha_q;
  logic [3:0] cpre_q;
  logic       error_q;
  logic       rx_valid_q;
  logic [7:0] rx_byte_q;

  logic timer_load;
  logic timer_en;
  logic timer_tc;

  // Terminal count is TIMEOUT-1 so a byte gets exactly TIMEOUT poll cycles.
  spi_poll_timer #(
    .TERMINAL(TIMEOUT - 16'd1)
  ) u_poll_timer (
    .clk  (Clk),
    .rst_n(Rst_n),
    .load (timer_load),
    .en   (timer_en),
    .tc   (timer_tc)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and register-port drive. The port is combinational because
  // the master answers reads in the same cycle the address is presented.
  always_comb begin
    state_d    = state_q;
    Addr       = ADDR_CTRL;
    Wr         = 1'b0;
    DataWr     = 8'h00;
    TxReady    = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = (Len != 8'd0) ? ST_SEL : ST_DONE;
        end
      end
      ST_SEL: begin
        Addr    = ADDR_SS;
        Wr      = 1'b1;
        DataWr  = ss_select_mask(slave_q);
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (TxValid) begin
          TxReady = 1'b1;
          Addr    = ADDR_TX;
          Wr      = 1'b1;
          DataWr  = TxByte;
          state_d = ST_GO;
        end
      end
      ST_GO: begin
        Addr       = ADDR_CTRL;
        Wr         = 1'b1;
        DataWr     = ctrl_start_word(cpre_q, cpha_q, cpol_q);
        timer_load = 1'b1;
        state_d    = ST_POLL;
      end
      ST_POLL: begin
        Addr = ADDR_CTRL;
        if (DataRd[DONE_BIT]) begin
          state_d = ST_READ;
        end else if (timer_tc) begin
          state_d = ST_DESEL;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_READ: begin
        Addr    = ADDR_RX;
        state_d = ST_RX_HOLD;
      end
      ST_RX_HOLD: begin
        if (RxReady) begin
          state_d = (remaining_q <= 8'd1) ? ST_DESEL : ST_WAIT_TX;
        end
      end
      ST_DESEL: begin
        Addr    = ADDR_SS;
        Wr      = 1'b1;
        DataWr  = 8'hFF;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Command latch, sticky error, RX holding register and byte countdown.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      slave_q     <= '0;
      remaining_q <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      cpre_q      <= '0;
      error_q     <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            slave_q     <= SlaveIdx;
            remaining_q <= Len;
            cpol_q      <= CPol;
            cpha_q      <= CPha;
            cpre_q      <= CPre;
            error_q     <= 1'b0;
          end
        end
        ST_POLL: begin
          if (!DataRd[DONE_BIT] && timer_tc) begin
            error_q <= 1'b1;
          end
        end
        ST_READ: begin
          rx_byte_q  <= DataRd;
          rx_valid_q <= 1'b1;
        end
        ST_RX_HOLD: begin
          if (RxReady) begin
            rx_valid_q <= 1'b0;
            if (remaining_q != 8'd0) begin
              remaining_q <= remaining_q - 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign Done    = (state_q == ST_DONE);
  assign Error   = error_q;
  assign RxValid = rx_valid_q;
  assign RxByte  = rx_byte_q;

endmodule

// File: tb/tb_spi_xfer_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_xfer_engine
// Directed bench for spi_xfer_engine. Stimulus pushes the expected register
// writes and RX bytes into queues; a monitor pops and compares them whenever
// the DUT writes the register port or hands over an RX byte. A small SPI
// master model answers status/RX reads, and an RX sink applies one stall.
// ---------------------------------------------------------------------------
module tb_spi_xfer_engine;
  import spi_pkg::*;

  localparam logic [15:0] TB_TIMEOUT = 16'd32;
  localparam int STALL_IDX = 2;
  localparam int STALL_LEN = 5;

  logic       Clk;
  logic       Rst_n;
  logic       Start;
  logic [2:0] SlaveIdx;
  logic [7:0] Len;
  logic       CPol;
  logic       CPha;
  logic [3:0] CPre;
  logic       TxValid;
  logic [7:0] TxByte;
  logic       TxReady;
  logic       RxValid;
  logic [7:0] RxByte;
  logic       RxReady;
  logic       Busy;
  logic       Done;
  logic       Error;
  logic [1:0] Addr;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] DataRd;

  spi_xfer_engine #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Start   (Start),
    .SlaveIdx(SlaveIdx),
    .Len     (Len),
    .CPol    (CPol),
    .CPha    (CPha),
    .CPre    (CPre),
    .TxValid (TxValid),
    .TxByte  (TxByte),
    .TxReady (TxReady),
    .RxValid (RxValid),
    .RxByte  (RxByte),
    .RxReady (RxReady),
    .Busy    (Busy),
    .Done    (Done),
    .Error   (Error),
    .Addr    (Addr),
    .Wr      (Wr),
    .DataWr  (DataWr),
    .DataRd  (DataRd)
  );

  // Free-running clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // SPI master model state (rx_table, done_delay, never_done set by stimulus).
  logic [7:0] rx_table [0:15];
  int  done_delay;
  bit  never_done;
  int  countdown;
  bit  slave_active;
  bit  slave_done;
  bit  prev_rx_read;
  int  rx_count;

  // Master model: a START write arms a countdown that raises DONE; the RX
  // pointer advances once the read cycle is over so the DUT samples it stably.
  always @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      countdown    <= 0;
      slave_active <= 1'b0;
      slave_done   <= 1'b0;
      prev_rx_read <= 1'b0;
    end else begin
      prev_rx_read <= (Addr == ADDR_RX);
      if (prev_rx_read && (Addr != ADDR_RX)) begin
        rx_count   <= rx_count + 1;
        slave_done <= 1'b0;
      end
      if (Wr && (Addr == ADDR_CTRL) && DataWr[START_BIT]) begin
        countdown    <= done_delay;
        slave_active <= 1'b1;
        slave_done   <= 1'b0;
      end else if (slave_active && !never_done) begin
        if (countdown <= 1) begin
          slave_done   <= 1'b1;
          slave_active <= 1'b0;
        end else begin
          countdown <= countdown - 1;
        end
      end
    end
  end

  // Register read data of the master model.
  always_comb begin
    DataRd = 8'h00;
    case (Addr)
      ADDR_CTRL: DataRd = {4'b0000, slave_done, 3'b000};
      ADDR_RX:   DataRd = rx_table[rx_count[3:0]];
      default:   DataRd = 8'h00;
    endcase
  end

  // RX sink: always ready except for a fixed stall on one chosen byte.
  int sink_acc;
  int sink_stalls;
  initial begin
    RxReady = 1'b1;
    forever begin
      @(negedge Clk);
      if (RxValid && RxReady) sink_acc++;
      @(posedge Clk);
      #1;
      if (RxValid && (sink_acc == STALL_IDX) && (sink_stalls < STALL_LEN)) begin
        RxReady = 1'b0;
        sink_stalls++;
      end else begin
        RxReady = 1'b1;
      end
    end
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int errors;
  int checks;
  logic [9:0] exp_wr [$];
  logic [7:0] exp_rx [$];
  logic [7:0] cmd_tx [$];
  logic [7:0] cmd_rx [$];
  int done_count;
  int tx_pulses;
  int wr_count;
  int stall_cycles;
  int stall_writes;
  int poll_cycles;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compares every register write and RX handover against the queues.
  task automatic monitor();
    logic [9:0] e;
    logic [7:0] r;
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (Wr) begin
          wr_count++;
          if (RxValid && !RxReady) stall_writes++;
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wr_unexpected: got addr=%0d data=0x%02h required no write",
                     Addr, DataWr);
          end else begin
            e = exp_wr.pop_front();
            checkOutput("wr", {22'd0, Addr, DataWr}, {22'd0, e});
          end
        end
        if (RxValid && RxReady) begin
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_unexpected: got 0x%02h required no byte", RxByte);
          end else begin
            r = exp_rx.pop_front();
            checkOutput("rx", {24'd0, RxByte}, {24'd0, r});
          end
        end
        if (Done) done_count++;
        if (TxReady) tx_pulses++;
        if (RxValid && !RxReady) stall_cycles++;
        if (Busy && !Wr && (Addr == ADDR_CTRL)) poll_cycles++;
      end
    end
  endtask

  // Queue the expected writes/RX bytes, issue the command and feed TX bytes.
  // kind: 0 = completes, 1 = times out on its byte, 2 = aborted by reset.
  task automatic applyStimulus(input logic [2:0] idx, input logic [7:0] len,
                               input logic cpol, input logic cpha,
                               input logic [3:0] cpre, input logic [7:0] exp_ss,
                               input logic [7:0] exp_ctrl, input int gap,
                               input int kind, input bit mutate);
    bit seen;
    if (len != 8'd0) begin
      exp_wr.push_back({ADDR_SS, exp_ss});
      for (int i = 0; i < int'(len); i++) begin
        exp_wr.push_back({ADDR_TX, cmd_tx[i]});
        exp_wr.push_back({ADDR_CTRL, exp_ctrl});
        if (kind == 0) exp_rx.push_back(cmd_rx[i]);
      end
      if (kind != 2) exp_wr.push_back({ADDR_SS, 8'hFF});
    end
    SlaveIdx = idx;
    Len      = len;
    CPol     = cpol;
    CPha     = cpha;
    CPre     = cpre;
    Start    = 1'b1;
    nextCycle();
    Start = 1'b0;
    if (mutate) begin
      CPol     = ~cpol;
      CPha     = ~cpha;
      CPre     = ~cpre;
      SlaveIdx = idx + 3'd1;
      Len      = 8'd9;
    end
    for (int i = 0; i < int'(len); i++) begin
      repeat (gap) nextCycle();
      TxValid = 1'b1;
      TxByte  = cmd_tx[i];
      seen    = 1'b0;
      for (int c = 0; (c < 300) && !seen; c++) begin
        @(negedge Clk);
        if (TxReady) seen = 1'b1;
      end
      checkOutput("tx_handshake", {31'd0, seen}, 32'd1);
      nextCycle();
      TxValid = 1'b0;
    end
  endtask

  task automatic waitDone(input int limit, output int cycles);
    int d0;
    d0     = done_count;
    cycles = 0;
    for (int n = 1; (n <= limit) && (cycles == 0); n++) begin
      @(negedge Clk);
      #1;
      if (done_count > d0) cycles = n;
    end
    if (cycles == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no Done in %0d cycles required Done", limit);
    end
  endtask

  // Directed test sequence.
  initial begin
    int cyc;
    int mark;
    errors = 0;
    checks = 0;
    fork
      monitor();
    join_none

    Rst_n      = 1'b0;
    Start      = 1'b0;
    SlaveIdx   = 3'd0;
    Len        = 8'd0;
    CPol       = 1'b0;
    CPha       = 1'b0;
    CPre       = 4'd0;
    TxValid    = 1'b0;
    TxByte     = 8'h00;
    done_delay = 4;
    never_done = 1'b0;
    for (int i = 0; i < 16; i++) rx_table[i] = 8'h00;
    rx_table[0] = 8'h3C;
    rx_table[1] = 8'h11;
    rx_table[2] = 8'h22;
    rx_table[3] = 8'h33;
    rx_table[4] = 8'h44;
    rx_table[5] = 8'h5A;
    rx_table[6] = 8'hC3;
    rx_table[7] = 8'h7E;

    // Reset values.
    repeat (3) nextCycle();
    checkOutput("rst_busy",    {31'd0, Busy},    32'd0);
    checkOutput("rst_done",    {31'd0, Done},    32'd0);
    checkOutput("rst_error",   {31'd0, Error},   32'd0);
    checkOutput("rst_txready", {31'd0, TxReady}, 32'd0);
    checkOutput("rst_rxvalid", {31'd0, RxValid}, 32'd0);
    checkOutput("rst_rxbyte",  {24'd0, RxByte},  32'd0);
    checkOutput("rst_wr",      {31'd0, Wr},      32'd0);
    checkOutput("rst_addr",    {30'd0, Addr},    {30'd0, ADDR_CTRL});
    checkOutput("rst_datawr",  {24'd0, DataWr},  32'd0);
    Rst_n = 1'b1;
    nextCycle();

    // Reset in the middle of POLL: no deselect write, status cleared at once.
    $display("[TB] reset during poll");
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'h99);
    done_delay = 25;
    applyStimulus(3'd4, 8'd1, 1'b0, 1'b0, 4'h0, 8'hEF, 8'h01, 0, 2, 1'b0);
    repeat (4) nextCycle();
    checkOutput("abort_busy_before", {31'd0, Busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",    {31'd0, Busy},    32'd0);
    checkOutput("abort_wr",      {31'd0, Wr},      32'd0);
    checkOutput("abort_rxvalid", {31'd0, RxValid}, 32'd0);
    checkOutput("abort_error",   {31'd0, Error},   32'd0);
    nextCycle();
    checkOutput("abort_pending_wr", exp_wr.size(), 32'd0);
    Rst_n = 1'b1;
    repeat (3) nextCycle();

    // Single byte on slave 2.
    $display("[TB] single byte");
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'hA5);
    cmd_rx.push_back(8'h3C);
    done_delay = 20;
    applyStimulus(3'd2, 8'd1, 1'b0, 1'b0, 4'h0, 8'hFB, 8'h01, 0, 0, 1'b0);
    waitDone(100, cyc);
    checkOutput("single_busy_at_done", {31'd0, Busy}, 32'd0);
    checkOutput("single_wr_drained", exp_wr.size(), 32'd0);
    nextCycle();

    // Four-byte burst with TX gaps and an RX stall on the second byte.
    $display("[TB] burst with stalls");
    mark = tx_pulses;
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'h01); cmd_tx.push_back(8'h02);
    cmd_tx.push_back(8'h03); cmd_tx.push_back(8'h04);
    cmd_rx.push_back(8'h11); cmd_rx.push_back(8'h22);
    cmd_rx.push_back(8'h33); cmd_rx.push_back(8'h44);
    done_delay = 3;
    applyStimulus(3'd7, 8'd4, 1'b1, 1'b0, 4'h2, 8'h7F, 8'h23, 3, 0, 1'b0);
    waitDone(300, cyc);
    checkOutput("burst_tx_pulses", tx_pulses - mark, 32'd4);
    checkOutput("burst_stall_cycles", stall_cycles, STALL_LEN);
    checkOutput("burst_stall_writes", stall_writes, 32'd0);
    checkOutput("burst_rx_drained", exp_rx.size(), 32'd0);
    nextCycle();

    // Empty command: Done quickly with no register writes.
    $display("[TB] empty command");
    mark = wr_count;
    cmd_tx.delete(); cmd_rx.delete();
    applyStimulus(3'd0, 8'd0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0, 0, 1'b0);
    waitDone(2, cyc);
    checkOutput("empty_done_latency", {31'd0, (cyc >= 1) && (cyc <= 2)}, 32'd1);
    repeat (3) nextCycle();
    checkOutput("empty_no_wr", wr_count - mark, 32'd0);

    // Start while Busy is ignored.
    $display("[TB] start while busy");
    mark = done_count;
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'h5B);
    cmd_rx.push_back(8'h5A);
    done_delay = 10;
    applyStimulus(3'd1, 8'd1, 1'b0, 1'b0, 4'h0, 8'hFD, 8'h01, 0, 0, 1'b0);
    nextCycle();
    checkOutput("busy_during_cmd", {31'd0, Busy}, 32'd1);
    SlaveIdx = 3'd6;
    Len      = 8'd0;
    Start    = 1'b1;
    nextCycle();
    Start = 1'b0;
    waitDone(100, cyc);
    repeat (6) nextCycle();
    checkOutput("busy_done_count", done_count - mark, 32'd1);

    // Timeout: DONE never rises.
    $display("[TB] poll timeout");
    never_done = 1'b1;
    mark = poll_cycles;
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'h66);
    applyStimulus(3'd0, 8'd1, 1'b0, 1'b0, 4'h0, 8'hFE, 8'h01, 0, 1, 1'b0);
    waitDone(200, cyc);
    checkOutput("timeout_error", {31'd0, Error}, 32'd1);
    checkOutput("timeout_poll_cycles", poll_cycles - mark, {16'd0, TB_TIMEOUT});
    checkOutput("timeout_rxvalid", {31'd0, RxValid}, 32'd0);
    checkOutput("timeout_wr_drained", exp_wr.size(), 32'd0);
    never_done = 1'b0;
    nextCycle();
    checkOutput("timeout_error_sticky", {31'd0, Error}, 32'd1);
    cmd_tx.delete();
    applyStimulus(3'd0, 8'd0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0, 0, 1'b0);
    checkOutput("error_cleared_by_start", {31'd0, Error}, 32'd0);
    waitDone(4, cyc);
    nextCycle();

    // Mode latched at Start survives input changes mid-command.
    $display("[TB] mode latch");
    cmd_tx.delete(); cmd_rx.delete();
    cmd_tx.push_back(8'h81); cmd_tx.push_back(8'h82);
    cmd_rx.push_back(8'hC3); cmd_rx.push_back(8'h7E);
    done_delay = 5;
    applyStimulus(3'd3, 8'd2, 1'b1, 1'b1, 4'h9, 8'hF7, 8'h97, 1, 0, 1'b1);
    waitDone(200, cyc);
    checkOutput("mode_wr_drained", exp_wr.size(), 32'd0);
    repeat (3) nextCycle();

    checkOutput("final_rx_drained", exp_rx.size(), 32'd0);
    checkOutput("final_wr_drained", exp_wr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
